// File: rtl/fpmul_uart_host.sv
// rtl/fpmul_uart_host.sv - host-side FPMUL-over-UART initiator: sends A/B command frame, receives P/flags.
module fpmul_uart_host #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        tx,
  input  logic        rx,
  output logic        rsp_valid,
  output logic [31:0] p,
  output logic [5:0]  flags,
  output logic        err,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
  state_t state, state_n;

  logic [71:0]   tx_sr;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [3:0]    tx_byte;
  logic [6:0]    tx_idx;
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_active;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_data;
  logic [2:0]    rx_bytes;
  logic [37:0]   rsp_word;
  logic [TW-1:0] tmo_cnt;
  logic          tx_tick, tx_done, rx_tick, rx_bad, rx_last, timeout;
  logic          err_set, rsp_set;

  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_done = (state == SEND) && tx_tick && (tx_bit == 4'd9) && (tx_byte == 4'd8);
  assign rx_tick = rx_active && (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST));
  assign rx_bad  = rx_tick && (rx_bit == 4'd9) && !rx_s2;
  assign rx_last = rx_tick && (rx_bit == 4'd9) && rx_s2 && (rx_bytes == 3'd4);
  assign timeout = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    err_set   = 1'b0;
    rsp_set   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_n = SEND;
      end
      SEND: if (tx_done) state_n = RECV;
      RECV: begin
        if (timeout || rx_bad) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (rx_last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        rsp_set = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Data bits 1..8 of the current frame come from the top byte of the shift register.
  always_comb begin
    tx     = 1'b1;
    tx_idx = 7'd63 + {3'b000, tx_bit};
    if (state == SEND) begin
      if (tx_bit == 4'd0)      tx = 1'b0;
      else if (tx_bit != 4'd9) tx = tx_sr[tx_idx];
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state     <= IDLE;
      tx_sr     <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_byte   <= '0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_data   <= '0;
      rx_bytes  <= '0;
      rsp_word  <= '0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      p         <= '0;
      flags     <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= rsp_set;
      err       <= err_set;
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;

      if (state == IDLE && req_valid) begin
        tx_sr   <= {7'b0, 1'b1, a, b};
        tx_cnt  <= '0;
        tx_bit  <= '0;
        tx_byte <= '0;
      end else if (state == SEND) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            tx_bit  <= '0;
            tx_byte <= tx_byte + 1'b1;
            tx_sr   <= {tx_sr[63:0], 8'h00};
          end else begin
            tx_bit <= tx_bit + 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end

      // Receive engine only runs in RECV; anything on rx earlier is dropped.
      if (state != RECV) begin
        tmo_cnt   <= '0;
        rx_active <= 1'b0;
        rx_bytes  <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (!rx_active) begin
          if (rx_prev && !rx_s2) begin
            rx_active <= 1'b1;
            rx_cnt    <= '0;
            rx_bit    <= '0;
          end
        end else if (!rx_tick) begin
          rx_cnt <= rx_cnt + 1'b1;
        end else begin
          rx_cnt <= '0;
          if (rx_bit == 4'd0) begin
            if (rx_s2) rx_active <= 1'b0;
            else       rx_bit    <= 4'd1;
          end else if (rx_bit != 4'd9) begin
            rx_data <= {rx_s2, rx_data[7:1]};
            rx_bit  <= rx_bit + 1'b1;
          end else begin
            rx_active <= 1'b0;
            if (rx_s2) begin
              rsp_word <= {rsp_word[29:0], rx_data};
              rx_bytes <= rx_bytes + 1'b1;
            end
          end
        end
      end

      if (rsp_set) begin
        p     <= rsp_word[31:0];
        flags <= rsp_word[37:32];
      end
    end
  end
endmodule

// File: tb/tb_fpmul_uart_host.sv
// tb/tb_fpmul_uart_host.sv - scoreboard bench: checks command frames on tx and response decode/errors.
module tb_fpmul_uart_host;
  localparam int CPB = 16;
  localparam int TMO = 5000;

  logic        clk100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        tx;
  logic        rx = 1'b1;
  logic        rsp_valid;
  logic [31:0] p;
  logic [5:0]  flags;
  logic        err;
  logic        busy;

  fpmul_uart_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk100MHz(clk100MHz), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .tx(tx), .rx(rx), .rsp_valid(rsp_valid), .p(p), .flags(flags),
    .err(err), .busy(busy)
  );

  always #5 clk100MHz = ~clk100MHz;

  longint cyc = 0;
  always @(posedge clk100MHz) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [31:0] p;
    logic [5:0]  flags;
    longint      t_min;
    longint      t_max;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_p = '0;
  logic [5:0]  model_flags = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every output event must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk100MHz);
      if (rsp_valid === 1'b1 || err === 1'b1) begin
        check("rsp_err_exclusive", {63'b0, rsp_valid && err}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_event", {62'b0, rsp_valid, err}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {63'b0, err}, {63'b0, e.is_err});
          check("p_value", p, e.p);
          check("flags_value", flags, e.flags);
          if (e.t_max != 0)
            check("timeout_latency", {63'b0, (cyc >= e.t_min) && (cyc <= e.t_max)}, 64'd1);
        end
        @(negedge clk100MHz);
        check("pulse_then_idle", {60'b0, rsp_valid, err, req_ready, busy}, 64'b0010);
      end
    end
  end

  task automatic send_req(input logic [31:0] ta, input logic [31:0] tb);
    int k = 0;
    while (req_ready !== 1'b1 && k < 5000) begin
      @(negedge clk100MHz);
      k++;
    end
    check("req_ready_before_req", {63'b0, req_ready}, 64'd1);
    a = ta;
    b = tb;
    req_valid = 1'b1;
    @(negedge clk100MHz);
    req_valid = 1'b0;
    a = $urandom();
    b = $urandom();
    check("req_ready_fell", {63'b0, req_ready}, 64'd0);
    check("start_bit_latency", {63'b0, tx}, 64'd0);
  endtask

  // Called at the negedge of the first start-bit cycle; samples every bit at mid-bit.
  task automatic capture_cmd(input logic [31:0] ta, input logic [31:0] tb);
    logic [71:0] w;
    logic [7:0]  got;
    int frame_bad = 0;
    int ready_bad = 0;
    w = {7'b0, 1'b1, ta, tb};
    repeat (CPB / 2) @(negedge clk100MHz);
    for (int by = 0; by < 9; by++) begin
      if (tx !== 1'b0) frame_bad++;
      if (req_ready !== 1'b0) ready_bad++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk100MHz);
        got[i] = tx;
        if (req_ready !== 1'b0) ready_bad++;
      end
      repeat (CPB) @(negedge clk100MHz);
      if (tx !== 1'b1) frame_bad++;
      if (req_ready !== 1'b0) ready_bad++;
      check($sformatf("cmd_byte%0d", by), got, w[71 - 8 * by -: 8]);
      if (by < 8) repeat (CPB) @(negedge clk100MHz);
    end
    check("cmd_framing", frame_bad, 0);
    check("ready_low_in_frame", ready_bad, 0);
  endtask

  task automatic uart_send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk100MHz);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk100MHz);
    end
    rx = stop;
    repeat (CPB) @(negedge clk100MHz);
    rx = 1'b1;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk100MHz);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk100MHz);
  endtask

  // kind: 0 normal, 1 framing error on byte 2, 2 only two bytes then timeout
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb,
                         input logic [39:0] rw, input int kind, input logic glitch);
    exp_t e;
    longint t_end;
    logic [7:0] byte_v;
    send_req(ta, tb);
    capture_cmd(ta, tb);
    t_end = cyc;
    if (kind == 0) begin
      model_p     = rw[31:0];
      model_flags = rw[37:32];
    end
    e.is_err = (kind != 0);
    e.p      = model_p;
    e.flags  = model_flags;
    e.t_min  = (kind == 2) ? t_end + TMO - 10 : 0;
    e.t_max  = (kind == 2) ? t_end + TMO + 30 : 0;
    exp_q.push_back(e);
    repeat (CPB) @(negedge clk100MHz);
    if (glitch) begin
      rx = 1'b0;
      repeat ($urandom_range(2, 4)) @(negedge clk100MHz);
      rx = 1'b1;
      repeat (20) @(negedge clk100MHz);
    end
    for (int i = 0; i < 5; i++) begin
      if (kind == 2 && i == 2) break;
      byte_v = rw[39 - 8 * i -: 8];
      uart_send(byte_v, !(kind == 1 && i == 2));
      if (kind == 1 && i == 2) break;
      repeat ($urandom_range(0, 3)) @(negedge clk100MHz);
    end
    drain(TMO + 2000);
  endtask

  initial begin
    int tx_low;
    int kind;
    logic [39:0] rw;

    repeat (3) @(negedge clk100MHz);
    rst = 1'b0;
    tx_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk100MHz);
      if (tx !== 1'b1) tx_low++;
    end
    check("idle_tx_high", tx_low, 0);
    check("reset_req_ready", {63'b0, req_ready}, 64'd1);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_p", p, 0);
    check("reset_flags", flags, 0);

    run_txn(32'h3F800000, 32'h40000000, 40'h00_40000000, 0, 1'b0);
    run_txn(32'h3F800000, 32'h40000000, 40'h3F_7F800000, 0, 1'b0);
    run_txn(32'h12345678, 32'h9ABCDEF0, 40'h00_00000000, 0, 1'b0);
    run_txn(32'h12345678, 32'h9ABCDEF0, 40'hFF_7F800000, 0, 1'b1);
    run_txn(32'hC0490FDB, 32'h00000001, 40'h00_12345678, 1, 1'b0);
    run_txn(32'h7F800000, 32'hFFFFFFFF, 40'h01_00000000, 2, 1'b0);

    for (int t = 0; t < 10; t++) begin
      rw = {8'($urandom()), 32'($urandom())};
      kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
      run_txn($urandom(), $urandom(), rw, kind, ($urandom_range(0, 3) == 0));
    end

    send_req(32'h3F800000, 32'h40000000);
    repeat (200) @(negedge clk100MHz);
    rst = 1'b1;
    @(negedge clk100MHz);
    rst = 1'b0;
    check("abort_tx_high", {63'b0, tx}, 64'd1);
    check("abort_req_ready", {63'b0, req_ready}, 64'd1);
    check("abort_p_cleared", p, 0);
    model_p = '0;
    model_flags = '0;
    tx_low = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk100MHz);
      if (tx !== 1'b1) tx_low++;
    end
    check("after_abort_tx_idle", tx_low, 0);
    check("after_abort_flags", flags, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
